// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with prioritised redirects, epoch tagging and misalign halt
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int NUM_REDIR = 3,
  parameter int EPOCH_W = 2,
  parameter int C_EXT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target,
  input  logic                      fetch_ready,
  input  logic                      inst_is_c,
  output logic [XLEN-1:0]           pc,
  output logic [XLEN-1:0]           pc_seq,
  output logic                      fetch_valid,
  output logic [EPOCH_W-1:0]        epoch,
  output logic                      misalign_err
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]      state;
  logic            redir_any;
  logic [XLEN-1:0] redir_tgt;
  logic            tgt_aligned;
  logic [XLEN-1:0] step;

  // Walk from the highest index down so the lowest-index request is the last to overwrite.
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        redir_any = 1'b1;
        redir_tgt = redir_target[i*XLEN +: XLEN];
      end
    end
  end

  assign tgt_aligned = (C_EXT != 0) ? ~redir_tgt[0] : (redir_tgt[1:0] == 2'b00);
  assign step        = ((C_EXT != 0) && inst_is_c) ? XLEN'(2) : XLEN'(4);
  assign pc_seq      = pc + step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_VEC;
      fetch_valid  <= 1'b0;
      epoch        <= '0;
      misalign_err <= 1'b0;
    end else if (redir_any) begin
      // Redirect outranks any stall or handshake; a misaligned target is kept in pc for debug.
      pc    <= redir_tgt;
      epoch <= epoch + EPOCH_W'(1);
      if (tgt_aligned) begin
        state        <= RUN;
        fetch_valid  <= 1'b1;
        misalign_err <= 1'b0;
      end else begin
        state        <= HALT;
        fetch_valid  <= 1'b0;
        misalign_err <= 1'b1;
      end
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (fetch_valid && fetch_ready) begin
            pc <= pc_seq;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage; the successor to the single-source PC register. It adds the following over that register:
- a configurable reset vector;
- N prioritised redirect channels (e.g. trap, mispredict, branch/jump);
- optional compressed-instruction stepping (+2/+4);
- a valid/ready handshake toward instruction fetch;
- a fetch epoch tag, so downstream stages can discard stale in-flight fetches;
- a halt state on misaligned redirect targets.

## Interface
- XLEN, 32, address width.
- RESET_VEC, 0, PC value loaded on reset (XLEN bits).
- NUM_REDIR, 3, number of redirect channels; channel 0 has highest priority.
- EPOCH_W, 2, width of the fetch epoch tag.
- C_EXT, 0, 1 enables 16-bit instruction stepping and 2-byte target alignment.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- redir_valid  in  NUM_REDIR  per-channel redirect request.
- redir_target  in  NUM_REDIR*XLEN  channel i target at bits [i*XLEN +: XLEN].
- fetch_ready  in  1  fetch accepts the current pc this cycle.
- inst_is_c  in  1  the instruction at pc is 16-bit; ignored when C_EXT=0.
- pc  out  XLEN  current fetch address (registered).
- pc_seq  out  XLEN  pc + step, combinational.
- fetch_valid  out  1  pc is a valid fetch request (registered).
- epoch  out  EPOCH_W  tag of the current fetch stream (registered).
- misalign_err  out  1  high while halted on a misaligned target (registered).

## Operation
- **States:** BOOT, RUN, HALT.
- **Step:** 2 when C_EXT=1 and inst_is_c=1, otherwise 4.
  - pc_seq = pc + step, modulo 2^XLEN (wraps silently).
- **Redirect winner:** the lowest-index channel with redir_valid=1. Targets on all other channels are ignored, including their alignment.
- **Alignment:** with C_EXT=0 the target must have [1:0]=0; with C_EXT=1 it must have [0]=0.
- **Advance:** fetch_valid=1 and fetch_ready=1.
- **Priority, highest first:** reset, then redirect, then advance, then hold.
- **BOOT:**
  - No redirect: go to RUN with pc unchanged.
  - Redirect: apply it (see the redirect rule below).
- **RUN:**
  - Redirect: apply it.
  - Advance with no redirect: pc <= pc_seq.
  - Otherwise (stall): pc, epoch and fetch_valid are held.
- **Applying a redirect:**
  - pc <= winner target and epoch <= epoch+1 (wraps modulo 2^EPOCH_W).
  - Aligned target: state RUN, fetch_valid=1, misalign_err=0.
  - Misaligned target: state HALT, fetch_valid=0, misalign_err=1, and pc holds the bad target for debug.
- **Redirects are never lost to a stall.** They are applied even when fetch_ready=0; the unaccepted fetch is abandoned and the epoch changes.
- **HALT:**
  - Only a redirect leaves HALT. It follows the rules above, and re-entering HALT is allowed.
  - fetch_ready is ignored while in HALT.
- fetch_valid is 1 in RUN and 0 in BOOT and HALT.

## Timing
- **Reset values** (asynchronous on rst rising):
  - pc=RESET_VEC, fetch_valid=0, epoch=0, misalign_err=0, state=BOOT.
  - pc_seq = RESET_VEC + step.
- **Bring-up:** with no redirect, BOOT lasts exactly one edge after rst deasserts. fetch_valid=1 with pc=RESET_VEC from the following cycle.
- **Redirect latency:** 1 cycle. A redirect sampled at edge k gives the new pc, epoch and fetch_valid right after edge k.
- **Advance latency:** 1 cycle. pc updates on the edge that samples the handshake.
- **Simultaneous events:**
  - Redirect + advance in the same cycle: the redirect wins, and the accepted fetch keeps the old epoch.
  - Multiple redirects: the lowest-index channel wins, with a single epoch increment.
- **Reset mid-operation:** all state and outputs return to their reset values immediately; any pending redirect is dropped.
- **Outputs:** no combinational path from inputs to pc, fetch_valid, epoch or misalign_err. pc_seq depends combinationally on inst_is_c.

## Test plan
1. **Bring-up:**
   - Stimulus: RESET_VEC=32'h0000_1000; release rst; hold fetch_ready=1.
   - Response: one BOOT cycle, then pc sequence 1000, 1004, 1008; epoch=0.
2. **Stall then redirect:**
   - Stimulus: fetch_ready=0 for 3 cycles with pc=1008 held; then redir_valid[2]=1, target 2000, while still stalled.
   - Response: next cycle pc=2000, epoch=1, fetch_valid=1.
3. **Priority:**
   - Stimulus: in the same cycle, ch0 targets 3000, ch1 targets 4000, and an advance occurs.
   - Response: pc=3000; epoch increments exactly once.
4. **Misaligned target:**
   - Stimulus: C_EXT=0, ch1 target 5002.
   - Response: misalign_err=1, fetch_valid=0, pc=5002. fetch_ready pulses leave pc unchanged. A redirect to 6000 then gives RUN, misalign_err=0, epoch+1.
5. **Compressed stepping and wrap:**
   - Stimulus: C_EXT=1, pc=FFFF_FFFC, with inst_is_c pattern 1, 1, 0.
   - Response: pc sequence FFFF_FFFE, 0000_0000, 0000_0004.
   - Also: a target of 7002 is accepted without error.
6. **Epoch wrap and async reset:**
   - Stimulus: four redirects (EPOCH_W=2), then rst asserted mid-stall.
   - Response: epoch sequence 1, 2, 3, 0. The reset values appear before the next edge.
